ad_data_in_delay_cal: RTL and testbench

//  Per-lane IDELAY tap calibration controller for the CMOS ADC data inputs.

---
 rtl/ad_data_in_delay_cal.sv | 166 ++++++++++++++++
 tb/tb_ad_data_in_delay_cal.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ad_data_in_delay_cal.sv
// Per-lane IDELAY tap calibration: sweeps taps 0..31, scores a 1010 training
// bit, loads the centre of the widest clean window. Optional: AD_DATA_IN_DELAY_CAL_READBACK_EN.
//
// Ports: up_clk/up_rstn clock and async active-low reset;
//   cal_start (in) run request, adc_valid/adc_data (in) captured training bit,
//   up_drdata (in) tap readback, up_dld/up_dwdata (out) tap-load strobe/value,
//   cal_busy/cal_done/cal_fail (out) status, cal_tap/cal_window (out) result.
module ad_data_in_delay_cal #(
  parameter int SAMPLES_PER_TAP = 256,
  parameter int SETTLE_CYCLES   = 16,
  parameter int MIN_WINDOW      = 4
) (
  input  logic       up_clk,
  input  logic       up_rstn,
  input  logic       cal_start,
  input  logic       adc_valid,
  input  logic       adc_data,
  input  logic [4:0] up_drdata,
  output logic       up_dld,
  output logic [4:0] up_dwdata,
  output logic       cal_busy,
  output logic       cal_done,
  output logic       cal_fail,
  output logic [4:0] cal_tap,
  output logic [5:0] cal_window
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_SAMPLE, S_EVAL,
    S_NEXT, S_APPLY, S_VERIFY, S_DONE
  } state_t;

  localparam logic [15:0] SET_LAST = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] SMP_LAST = 16'(SAMPLES_PER_TAP - 1);
  localparam logic [5:0]  MIN_W    = 6'(MIN_WINDOW);

  state_t      state, state_n;
  logic [15:0] cnt;
  logic [4:0]  tap;
  logic        prev, seeded;
  logic [7:0]  err_cnt;
  logic [4:0]  run_start, best_start;
  logic [5:0]  run_len, best_len;

  logic        pass, closing, win_ok, vdone;
  logic [4:0]  nrun_start, cls_start, target;
  logic [5:0]  nrun_len, cls_len;

`ifdef AD_DATA_IN_DELAY_CAL_READBACK_EN
  assign vdone = (cnt == 16'd2);
`else
  logic unused_drdata;
  assign unused_drdata = ^up_drdata;
  assign vdone = 1'b1;
`endif

  assign win_ok = (best_len >= MIN_W);
  assign target = win_ok ? 5'(best_start + best_len[5:1]) : 5'd0;

  // Run tracking for the EVAL step; the tap-31 pass closes the run
  // including the current tap.
  always_comb begin
    pass       = (err_cnt == 8'd0);
    nrun_start = run_start;
    nrun_len   = run_len;
    cls_start  = run_start;
    cls_len    = run_len;
    closing    = 1'b1;
    if (pass) begin
      if (run_len == 6'd0) nrun_start = tap;
      nrun_len  = run_len + 6'd1;
      cls_start = nrun_start;
      cls_len   = nrun_len;
      closing   = (tap == 5'd31);
    end else begin
      nrun_len = 6'd0;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (cal_start) state_n = S_LOAD;
      S_LOAD:   state_n = S_SETTLE;
      S_SETTLE: if (cnt == SET_LAST) state_n = S_SAMPLE;
      S_SAMPLE: if (adc_valid && cnt == SMP_LAST) state_n = S_EVAL;
      S_EVAL:   state_n = (tap == 5'd31) ? S_APPLY : S_NEXT;
      S_NEXT:   state_n = S_LOAD;
      S_APPLY:  state_n = S_VERIFY;
      S_VERIFY: if (vdone) state_n = S_DONE;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  assign up_dld    = (state == S_LOAD) || (state == S_APPLY);
  assign up_dwdata = (state == S_APPLY) ? target : tap;
  assign cal_busy  = (state != S_IDLE);
  assign cal_done  = (state == S_DONE);

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state      <= S_IDLE;
      cnt        <= '0;
      tap        <= '0;
      prev       <= 1'b0;
      seeded     <= 1'b0;
      err_cnt    <= '0;
      run_start  <= '0;
      run_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
      cal_fail   <= 1'b0;
      cal_tap    <= '0;
      cal_window <= '0;
    end else begin
      state <= state_n;
      unique case (state)
        S_IDLE: if (cal_start) begin
          cal_fail   <= 1'b0;
          tap        <= '0;
          run_start  <= '0;
          run_len    <= '0;
          best_start <= '0;
          best_len   <= '0;
        end
        S_LOAD: cnt <= '0;
        S_SETTLE: begin
          cnt     <= (cnt == SET_LAST) ? 16'd0 : cnt + 16'd1;
          seeded  <= 1'b0;
          err_cnt <= '0;
        end
        S_SAMPLE: if (adc_valid) begin
          cnt    <= cnt + 16'd1;
          prev   <= adc_data;
          seeded <= 1'b1;
          if (seeded && adc_data == prev && err_cnt != 8'hff)
            err_cnt <= err_cnt + 8'd1;
        end
        S_EVAL: begin
          run_start <= nrun_start;
          run_len   <= nrun_len;
          if (closing && cls_len > best_len) begin
            best_start <= cls_start;
            best_len   <= cls_len;
          end
        end
        S_NEXT: tap <= tap + 5'd1;
        S_APPLY: begin
          cal_tap    <= target;
          cal_window <= best_len;
          cnt        <= '0;
          if (!win_ok) cal_fail <= 1'b1;
        end
        S_VERIFY: begin
          cnt <= cnt + 16'd1;
`ifdef AD_DATA_IN_DELAY_CAL_READBACK_EN
          if (vdone && up_drdata != cal_tap) cal_fail <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ad_data_in_delay_cal.sv
// Randomised bench for ad_data_in_delay_cal: a lane model that is clean only
// on chosen taps, checked against a window-search reference.
module tb_ad_data_in_delay_cal;

  localparam int SPT = 32;
  localparam int SET = 8;
  localparam int MINW = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cal_start = 1'b0;
  logic       adc_valid = 1'b0;
  logic       adc_data = 1'b0;
  logic [4:0] up_drdata;
  logic       up_dld;
  logic [4:0] up_dwdata;
  logic       cal_busy, cal_done, cal_fail;
  logic [4:0] cal_tap;
  logic [5:0] cal_window;

  int checks = 0;
  int failures = 0;

  logic [31:0] mask = '0;
  bit          stall = 0;
  bit          randv = 0;
  bit          force0 = 0;
  logic [4:0]  cur_tap = '0;
  logic [4:0]  ld_val = '0;
  int          dld_cnt = 0;
  int          done_cnt = 0;
  int          k = 0;
  bit          vtog = 0;

  always #5 clk = ~clk;

  ad_data_in_delay_cal #(
    .SAMPLES_PER_TAP(SPT),
    .SETTLE_CYCLES(SET),
    .MIN_WINDOW(MINW)
  ) dut (
    .up_clk(clk),
    .up_rstn(rst_n),
    .cal_start(cal_start),
    .adc_valid(adc_valid),
    .adc_data(adc_data),
    .up_drdata(up_drdata),
    .up_dld(up_dld),
    .up_dwdata(up_dwdata),
    .cal_busy(cal_busy),
    .cal_done(cal_done),
    .cal_fail(cal_fail),
    .cal_tap(cal_tap),
    .cal_window(cal_window)
  );

  assign up_drdata = force0 ? 5'd0 : ld_val;

  // Monitor and IDELAY model: latch each load, count strobes and done pulses.
  always @(negedge clk) begin
    if (up_dld) begin
      dld_cnt++;
      ld_val = up_dwdata;
      cur_tap = up_dwdata;
    end
    if (cal_done) done_cnt++;
  end

  // Lane model: clean taps give 1010..., other taps repeat a bit regularly.
  always @(negedge clk) begin
    if (stall) begin
      vtog = ~vtog;
      adc_valid = vtog;
    end else if (randv) adc_valid = ($urandom % 4) != 0;
    else adc_valid = 1'b1;
    if (adc_valid) begin
      k++;
      if (mask[cur_tap]) adc_data = ~adc_data;
      else if (k % 5 != 0) adc_data = ~adc_data;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rng(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Reference: widest run of clean taps, earliest on a tie.
  function automatic void model(input logic [31:0] m, input bit f0,
                                output int tap, output int win,
                                output int fl);
    int best = 0, bs = 0, i = 0, j;
    while (i < 32) begin
      if (m[i]) begin
        j = i;
        while (j < 32 && m[j]) j++;
        if (j - i > best) begin
          best = j - i;
          bs = i;
        end
        i = j;
      end else i++;
    end
    win = best;
    fl = (best < MINW) ? 1 : 0;
    tap = fl ? 0 : bs + best / 2;
`ifdef AD_DATA_IN_DELAY_CAL_READBACK_EN
    if (f0 && tap != 0) fl = 1;
`else
    if (f0) fl = fl;
`endif
  endfunction

  task automatic run_cal(input string nm, input logic [31:0] m,
                         input bit stl, input bit rv, input bit f0,
                         input bit mid, output int cyc);
    int et, ew, ef;
    bit got = 0;
    mask = m;
    stall = stl;
    randv = rv;
    force0 = f0;
    model(m, f0, et, ew, ef);
    @(negedge clk);
    dld_cnt = 0;
    done_cnt = 0;
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    cyc = 1;
    check({nm, "_busy"}, int'(cal_busy), 1);
    while (cyc < 20000 && !got) begin
      @(negedge clk);
      cyc++;
      cal_start = (mid && cyc == 300);
      if (cal_done) got = 1;
    end
    cal_start = 1'b0;
    check({nm, "_timeout"}, int'(got), 1);
    repeat (3) @(negedge clk);
    check({nm, "_done_cnt"}, done_cnt, 1);
    check({nm, "_idle"}, int'(cal_busy), 0);
    check({nm, "_dld_cnt"}, dld_cnt, 33);
    check({nm, "_loaded"}, int'(ld_val), et);
    check({nm, "_tap"}, int'(cal_tap), et);
    check({nm, "_window"}, int'(cal_window), ew);
    check({nm, "_fail"}, int'(cal_fail), ef);
  endtask

  initial begin
    int cyc, cyc_stall;
    // reset state
    repeat (3) @(negedge clk);
    check("rst_dld", int'(up_dld), 0);
    check("rst_busy", int'(cal_busy), 0);
    check("rst_fail", int'(cal_fail), 0);
    check("rst_tap", int'(cal_tap), 0);
    check("rst_window", int'(cal_window), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // reset in the middle of SAMPLE at tap 2
    mask = rng(8, 19);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_busy", int'(cal_busy), 1);
    rst_n = 1'b0;
    dld_cnt = 0;
    #1;
    check("mid_rst_dld", int'(up_dld), 0);
    check("mid_rst_busy", int'(cal_busy), 0);
    check("mid_rst_done", int'(cal_done), 0);
    check("mid_rst_dwdata", int'(up_dwdata), 0);
    check("mid_rst_tap", int'(cal_tap), 0);
    check("mid_rst_win", int'(cal_window), 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("post_rst_dld", dld_cnt, 0);
    check("post_rst_busy", int'(cal_busy), 0);

    run_cal("eye", rng(8, 19), 0, 0, 0, 0, cyc);
    check("eye_lat_lo", int'(cyc >= 32 * (1 + SET + SPT + 2)), 1);
    check("eye_lat_hi", int'(cyc <= 32 * (1 + SET + SPT + 2) + 8), 1);
    run_cal("tie", rng(0, 5) | rng(20, 25), 0, 0, 0, 0, cyc);
    run_cal("edge", rng(26, 31), 0, 0, 0, 0, cyc);
    run_cal("closed", rng(10, 12), 0, 0, 0, 0, cyc);
    run_cal("all", 32'hffff_ffff, 0, 0, 0, 0, cyc);
    run_cal("none", 32'h0, 0, 0, 0, 0, cyc);
    run_cal("stall", rng(8, 19), 1, 0, 0, 1, cyc_stall);
    check("stall_lat", int'(cyc_stall >= 32 * (1 + SET + 2 * SPT)), 1);
    run_cal("rdbk", rng(8, 19), 0, 0, 1, 0, cyc);
    for (int r = 0; r < 3; r++) begin
      logic [31:0] rm;
      rm = $urandom & $urandom;
      run_cal($sformatf("rand%0d", r), rm, 0, 1, 0, 0, cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
